// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access path: load/store op codes,
// memory store-size codes, arbiter state and port-owner types.
package dmem_pkg;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_B  = 3'b001;
    localparam logic [2:0] OP_H  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b011;
    localparam logic [2:0] OP_HU = 3'b100;

    localparam logic [1:0] SS_W = 2'b00;
    localparam logic [1:0] SS_B = 2'b01;
    localparam logic [1:0] SS_H = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    // Access size in bytes; 0 marks an op code with no defined meaning.
    function automatic logic [2:0] op_bytes(input logic [2:0] op);
        case (op)
            OP_W:        return 3'd4;
            OP_B, OP_BU: return 3'd1;
            OP_H, OP_HU: return 3'd2;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-result extension: the memory returns zero-extended data, signed
// byte/half loads get their sign bit replicated here.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Sign-extend signed sub-word loads, pass everything else through.
    always_comb begin
        ext = raw;
        case (op)
            OP_B:    ext = {{24{raw[7]}}, raw[7:0]};
            OP_H:    ext = {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter and access sequencer for the data memory.
// Each grant becomes IDLE -> ACCESS -> RESP: one memory cycle, then a
// one-cycle response pulse to the owning port. Ties alternate between ports.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DMEM_BYTES = 1024
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_op,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_resp_valid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,
    output logic              mem_ena,
    output logic              mem_write,
    output logic              mem_read,
    output logic [1:0]        mem_ssignal,
    output logic [2:0]        mem_lsignal,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W+1:0] CAP = (ADDR_W+2)'(DMEM_BYTES);
    localparam logic [ADDR_W+1:0] ONE = (ADDR_W+2)'(1);

    state_t            state_q, state_d;
    owner_t            last_grant, owner;
    logic              we_q, err_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, ext_data;

    logic              idle, take, access_en, resp_on;
    logic              req_we, req_err;
    logic [2:0]        req_op, req_bytes;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [ADDR_W+1:0] last_byte;

    // Arbitration: a lone requester always wins, a tie goes to the port
    // that did not win last time.
    always_comb begin
        idle      = (state_q == ST_IDLE) && !rst;
        cpu_ready = idle && cpu_valid && (!dbg_valid || last_grant == OWN_DBG);
        dbg_ready = idle && dbg_valid && (!cpu_valid || last_grant == OWN_CPU);
        take      = cpu_ready || dbg_ready;
    end

    // Select the winning request and classify it (bad op, illegal store
    // width, or access running past the end of memory).
    always_comb begin
        req_we    = dbg_ready ? dbg_we    : cpu_we;
        req_op    = dbg_ready ? dbg_op    : cpu_op;
        req_addr  = dbg_ready ? dbg_addr  : cpu_addr;
        req_wdata = dbg_ready ? dbg_wdata : cpu_wdata;
        req_bytes = op_bytes(req_op);
        last_byte = {2'b00, req_addr} + {{(ADDR_W-1){1'b0}}, req_bytes} - ONE;
        req_err   = (req_bytes == 3'd0)
                 || (req_we && (req_op == OP_BU || req_op == OP_HU))
                 || (last_byte >= CAP);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: one cycle each in ACCESS and RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    dmem_load_ext u_ext (
        .op  (op_q),
        .raw (mem_rdata),
        .ext (ext_data)
    );

    // Latch the granted request; capture load data at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_DBG;
            owner      <= OWN_CPU;
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else if (take) begin
            owner      <= dbg_ready ? OWN_DBG : OWN_CPU;
            last_grant <= dbg_ready ? OWN_DBG : OWN_CPU;
            we_q       <= req_we;
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= req_err;
        end else if (state_q == ST_ACCESS) begin
            rdata_q    <= (err_q || we_q) ? 32'd0 : ext_data;
        end
    end

    // Memory strobes only during a good ACCESS; rst kills them at once so a
    // reset during ACCESS never lets the falling-edge write happen.
    always_comb begin
        access_en   = (state_q == ST_ACCESS) && !err_q && !rst;
        mem_ena     = access_en;
        mem_write   = access_en && we_q;
        mem_read    = access_en && !we_q;
        mem_ssignal = SS_W;
        if (state_q == ST_ACCESS) begin
            case (op_q)
                OP_B, OP_BU: mem_ssignal = SS_B;
                OP_H, OP_HU: mem_ssignal = SS_H;
                default:     mem_ssignal = SS_W;
            endcase
        end
        mem_lsignal = op_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
    end

    // Response pulse to the owner only; reset in RESP suppresses it.
    always_comb begin
        resp_on        = (state_q == ST_RESP) && !rst;
        cpu_resp_valid = resp_on && (owner == OWN_CPU);
        dbg_resp_valid = resp_on && (owner == OWN_DBG);
        cpu_rdata      = cpu_resp_valid ? rdata_q : 32'd0;
        dbg_rdata      = dbg_resp_valid ? rdata_q : 32'd0;
        cpu_err        = cpu_resp_valid && err_q;
        dbg_err        = dbg_resp_valid && err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory environment
// (falling-edge writes, zero-extending reads) plus a transaction-level
// reference memory that predicts every response.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_ready, cpu_we, cpu_resp_valid, cpu_err;
    logic [2:0]  cpu_op;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dbg_valid, dbg_ready, dbg_we, dbg_resp_valid, dbg_err;
    logic [2:0]  dbg_op;
    logic [10:0] dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        mem_ena, mem_write, mem_read;
    logic [1:0]  mem_ssignal;
    logic [2:0]  mem_lsignal;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    bit last_dbg = 1'b1;
    bit mem_init_done = 1'b0;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    dmem_arbiter #(.ADDR_W(11), .DMEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_op(cpu_op),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_op(dbg_op),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_resp_valid(dbg_resp_valid),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_ena(mem_ena), .mem_write(mem_write), .mem_read(mem_read),
        .mem_ssignal(mem_ssignal), .mem_lsignal(mem_lsignal), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic int ld_bytes(input logic [2:0] l);
        if (l == 3'b001 || l == 3'b011) return 1;
        if (l == 3'b010 || l == 3'b100) return 2;
        return 4;
    endfunction

    // Memory environment: falling-edge writes sized by mem_ssignal.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] = pat(i);
            mem_init_done = 1'b1;
        end else if (mem_ena && mem_write) begin
            for (int k = 0; k < ((mem_ssignal == 2'b01) ? 1 : (mem_ssignal == 2'b10) ? 2 : 4); k++)
                if (int'(mem_addr) + k < 1024) mem[int'(mem_addr) + k] = mem_wdata[8*k +: 8];
        end
    end

    // Combinational, zero-extending read sized by mem_lsignal.
    always_comb begin
        mem_rdata = 32'd0;
        for (int k = 0; k < 4; k++)
            if (k < ld_bytes(mem_lsignal) && int'(mem_addr) + k < 1024)
                mem_rdata[8*k +: 8] = mem[int'(mem_addr) + k];
    end

    // Reference: what one access should do to memory and return.
    task automatic model(input bit we, input logic [2:0] op, input logic [10:0] a,
                         input logic [31:0] wd, output bit e, output logic [31:0] rd);
        int n;
        longint v;
        n = (op == 0) ? 4 : (op == 1 || op == 3) ? 1 : (op == 2 || op == 4) ? 2 : 0;
        e = (n == 0) || (we && (op == 3 || op == 4)) || (int'(a) + n - 1 >= 1024);
        rd = 32'd0;
        if (!e && we) begin
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = 8'((longint'(wd) >> (8 * k)) % 256);
        end else if (!e) begin
            v = 0;
            for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[int'(a) + k]) << (8 * k));
            if (op == 1 && v >= 128)   v = v - 256;
            if (op == 2 && v >= 32768) v = v - 65536;
            rd = 32'(v);
        end
    endtask

    // Drive one request on a port and follow it through ACCESS and RESP.
    task automatic xfer(input bit dbg, input bit we, input logic [2:0] op, input logic [10:0] a,
                        input logic [31:0] wd, output bit acc, output int tries, output int acc_cyc,
                        output bit rv, output logic [31:0] rd, output bit re,
                        output bit ena_seen, output bit stray);
        acc = 0; tries = 0; acc_cyc = -1; rv = 0; rd = '0; re = 0; ena_seen = 0; stray = 0;
        if (dbg) begin dbg_valid = 1; dbg_we = we; dbg_op = op; dbg_addr = a; dbg_wdata = wd; end
        else     begin cpu_valid = 1; cpu_we = we; cpu_op = op; cpu_addr = a; cpu_wdata = wd; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tries++;
            if (dbg ? dbg_ready : cpu_ready) begin acc = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (dbg) dbg_valid = 0; else cpu_valid = 0;
        if (!acc) return;
        acc_cyc = cyc;
        last_dbg = dbg;
        @(negedge clk);
        ena_seen = mem_ena;
        stray = cpu_ready | dbg_ready | cpu_resp_valid | dbg_resp_valid;
        @(posedge clk); #1;
        @(negedge clk);
        rv = dbg ? dbg_resp_valid : cpu_resp_valid;
        rd = dbg ? dbg_rdata : cpu_rdata;
        re = dbg ? dbg_err : cpu_err;
        stray = stray | cpu_ready | dbg_ready | (dbg ? cpu_resp_valid : dbg_resp_valid);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; cpu_valid = 1; dbg_valid = 1;
        cpu_we = 0; cpu_op = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_we = 0; dbg_op = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++; if ({cpu_ready, dbg_ready} !== 2'b00) begin errs++; $display("FAIL reset_ready got=%b exp=00", {cpu_ready, dbg_ready}); end
        vecs++; if ({cpu_resp_valid, dbg_resp_valid, cpu_err, dbg_err} !== 4'b0) begin errs++; $display("FAIL reset_resp got=%b exp=0000", {cpu_resp_valid, dbg_resp_valid, cpu_err, dbg_err}); end
        vecs++; if ({cpu_rdata, dbg_rdata} !== 64'd0) begin errs++; $display("FAIL reset_rdata got=%h exp=0", {cpu_rdata, dbg_rdata}); end
        vecs++; if ({mem_ena, mem_write, mem_read} !== 3'b000) begin errs++; $display("FAIL reset_strobes got=%b exp=000", {mem_ena, mem_write, mem_read}); end
        vecs++; if ({mem_addr, mem_wdata, mem_lsignal, mem_ssignal} !== 48'd0) begin errs++; $display("FAIL reset_memfields got=%h exp=0", {mem_addr, mem_wdata, mem_lsignal, mem_ssignal}); end
        cpu_valid = 0; dbg_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        last_dbg = 1;
    endtask

    task automatic test_alternation();
        int gc = 0;
        int last_c = 0;
        bit got;
        cpu_valid = 1; cpu_we = 0; cpu_op = 3'b000; cpu_addr = 11'h100; cpu_wdata = 0;
        dbg_valid = 1; dbg_we = 0; dbg_op = 3'b000; dbg_addr = 11'h204; dbg_wdata = 0;
        for (int c = 0; c < 40 && gc < 4; c++) begin
            @(negedge clk);
            vecs++; if (cpu_ready && dbg_ready) begin errs++; $display("FAIL alt_both_ready cycle=%0d got=11 exp=one", c); end
            if (cpu_ready || dbg_ready) begin
                got = dbg_ready;
                vecs++; if (got !== !last_dbg) begin errs++; $display("FAIL alt_grant n=%0d got_dbg=%0d exp_dbg=%0d", gc, got, !last_dbg); end
                if (gc > 0) begin
                    vecs++; if (c - last_c !== 3) begin errs++; $display("FAIL alt_spacing n=%0d got=%0d exp=3", gc, c - last_c); end
                end
                last_c = c; last_dbg = got; gc++;
            end
            @(posedge clk); #1;
        end
        cpu_valid = 0; dbg_valid = 0;
        vecs++; if (gc !== 4) begin errs++; $display("FAIL alt_count got=%0d exp=4", gc); end
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        bit acc, rv, re, ena, stray, me; int t, ac; logic [31:0] rd, mr;
        model(1, 3'b000, 11'h010, 32'h80FF_1234, me, mr);
        xfer(0, 1, 3'b000, 11'h010, 32'h80FF_1234, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv, re, ena, stray, rd} !== {5'b11010, 32'd0}) begin errs++; $display("FAIL sw_resp got=%b/%h exp=11010/0", {acc, rv, re, ena, stray}, rd); end
        vecs++; if ({mem[19], mem[18], mem[17], mem[16]} !== 32'h80FF_1234) begin errs++; $display("FAIL sw_bytes got=%h exp=80ff1234", {mem[19], mem[18], mem[17], mem[16]}); end
        xfer(0, 0, 3'b001, 11'h010, 0, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv, re, stray} !== 4'b1100 || rd !== 32'h0000_0034) begin errs++; $display("FAIL lb got=%b/%h exp=1100/00000034", {acc, rv, re, stray}, rd); end
        xfer(0, 0, 3'b010, 11'h012, 0, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv, re} !== 3'b110 || rd !== 32'hFFFF_80FF) begin errs++; $display("FAIL lh got=%b/%h exp=110/ffff80ff", {acc, rv, re}, rd); end
        xfer(0, 0, 3'b100, 11'h012, 0, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv, re} !== 3'b110 || rd !== 32'h0000_80FF) begin errs++; $display("FAIL lhu got=%b/%h exp=110/000080ff", {acc, rv, re}, rd); end
    endtask

    task automatic test_oob();
        bit acc, rv, re, ena, stray, me; int t, ac; logic [31:0] rd, mr;
        model(1, 3'b000, 11'h3FD, 32'hCAFE_F00D, me, mr);
        xfer(1, 1, 3'b000, 11'h3FD, 32'hCAFE_F00D, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv, re, ena, stray} !== 5'b11100 || rd !== 32'd0) begin errs++; $display("FAIL oob_store got=%b/%h exp=11100/0", {acc, rv, re, ena, stray}, rd); end
        vecs++; if ({mem[1023], mem[1022], mem[1021]} !== {ref_mem[1023], ref_mem[1022], ref_mem[1021]}) begin errs++; $display("FAIL oob_bytes got=%h exp=%h", {mem[1023], mem[1022], mem[1021]}, {ref_mem[1023], ref_mem[1022], ref_mem[1021]}); end
    endtask

    task automatic test_bad_store();
        bit acc, rv, re, ena, stray, me; int t, ac; logic [31:0] rd, mr;
        model(1, 3'b011, 11'h020, 32'h0000_0055, me, mr);
        xfer(0, 1, 3'b011, 11'h020, 32'h0000_0055, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv, re, ena} !== 4'b1110) begin errs++; $display("FAIL sbu_store got=%b exp=1110", {acc, rv, re, ena}); end
        model(1, 3'b001, 11'h020, 32'h1234_56AB, me, mr);
        xfer(0, 1, 3'b001, 11'h020, 32'h1234_56AB, acc, t, ac, rv, rd, re, ena, stray);
        model(0, 3'b000, 11'h020, 0, me, mr);
        xfer(0, 0, 3'b000, 11'h020, 0, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if (rd !== mr || rd[7:0] !== 8'hAB || re !== 1'b0) begin errs++; $display("FAIL lw_after_sb got=%h exp=%h", rd, mr); end
    endtask

    task automatic test_reset_mid();
        bit acc, rv, re, ena, stray, me, any_rv; int t, ac; logic [31:0] rd, mr;
        cpu_valid = 1; cpu_we = 1; cpu_op = 3'b000; cpu_addr = 11'h040; cpu_wdata = 32'hDEAD_BEEF;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ready) begin acc = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cpu_valid = 0; rst = 1;
        @(negedge clk);
        vecs++; if ({acc, mem_ena, mem_write} !== 3'b100) begin errs++; $display("FAIL rstmid_ena got=%b exp=100", {acc, mem_ena, mem_write}); end
        @(posedge clk); #1;
        rst = 0; last_dbg = 1;
        any_rv = 0;
        repeat (2) begin @(negedge clk); any_rv = any_rv | cpu_resp_valid | dbg_resp_valid; end
        vecs++; if (any_rv !== 1'b0) begin errs++; $display("FAIL rstmid_resp got=%b exp=0", any_rv); end
        @(posedge clk); #1;
        model(0, 3'b000, 11'h040, 0, me, mr);
        xfer(0, 0, 3'b000, 11'h040, 0, acc, t, ac, rv, rd, re, ena, stray);
        vecs++; if ({acc, rv} !== 2'b11 || t !== 1 || rd !== mr) begin errs++; $display("FAIL rstmid_lw got=%b/%0d/%h exp=11/1/%h", {acc, rv}, t, rd, mr); end
    endtask

    task automatic test_dbg_only();
        bit acc, rv, re, ena, stray, me; int t, ac, prev; logic [31:0] rd, mr, wd; logic [10:0] a;
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            a = 11'($urandom_range(0, 1020));
            wd = $urandom;
            model(n[0], 3'b000, a, wd, me, mr);
            xfer(1, n[0], 3'b000, a, wd, acc, t, ac, rv, rd, re, ena, stray);
            vecs++; if ({acc, rv, re, stray} !== 4'b1100 || rd !== mr) begin errs++; $display("FAIL dbg_only n=%0d got=%b/%h exp=1100/%h", n, {acc, rv, re, stray}, rd, mr); end
            if (prev >= 0) begin
                vecs++; if (ac - prev !== 3) begin errs++; $display("FAIL dbg_rate n=%0d got=%0d exp=3", n, ac - prev); end
            end
            prev = ac;
        end
    endtask

    task automatic test_random();
        bit acc, rv, re, ena, stray, me, we, port; int t, ac, bad; logic [31:0] rd, mr, wd; logic [2:0] op; logic [10:0] a;
        for (int n = 0; n < 60; n++) begin
            port = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            case ($urandom_range(0, 3))
                0:       a = 11'($urandom_range(1016, 1030));
                1:       a = 11'($urandom_range(0, 2047));
                default: a = 11'($urandom_range(0, 1023));
            endcase
            wd = $urandom;
            model(we, op, a, wd, me, mr);
            xfer(port, we, op, a, wd, acc, t, ac, rv, rd, re, ena, stray);
            vecs++; if ({acc, rv, re, ena, stray} !== {2'b11, me, !me, 1'b0} || rd !== mr) begin errs++; $display("FAIL rand n=%0d we=%0d op=%0d a=%h got=%b/%h exp=%b/%h", n, we, op, a, {acc, rv, re, ena, stray}, rd, {2'b11, me, !me, 1'b0}, mr); end
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        vecs++; if (bad !== 0) begin errs++; $display("FAIL rand_mem_image got=%0d differing bytes exp=0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        test_reset();
        test_alternation();
        test_store_load();
        test_oob();
        test_bad_store();
        test_reset_mid();
        test_dbg_only();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
